// File: rtl/mw_pipe_reg.sv
// M->W pipeline register: stall/flush control, load-data extraction and misaligned-load
// suppression. Define MW_RETIRE_CNT_EN to add the retire_cnt output and its counter.
module mw_pipe_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC4_M,
    input  logic [31:0] PC8_M,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] DMrd_M,
    input  logic [4:0]  RDst_M,
    input  logic        regwrite_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC4_W,
    output logic [31:0] PC8_W,
    output logic [31:0] ALUout_W,
    output logic [31:0] DMout_W,
    output logic [4:0]  RDst_W,
    output logic        regwrite_W,
    output logic        valid_W,
    output logic        adel_W
`ifdef MW_RETIRE_CNT_EN
   ,output logic [31:0] retire_cnt
`endif
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [31:0] alu;
        logic [31:0] raw;
        logic [4:0]  rdst;
        logic        regwrite;
        logic        valid;
        logic        adel;
    } w_state_t;

    localparam w_state_t RST_STATE = '{
        ir: '0, pc4: RESET_PC + 32'd4, pc8: RESET_PC + 32'd8, alu: '0, raw: '0,
        rdst: '0, regwrite: 1'b0, valid: 1'b0, adel: 1'b0};

    w_state_t   st_q, cap_d, bub_d;
    logic [5:0] op_m;
    logic       mis_m;

    always_comb begin
        op_m  = IR_M[31:26];
        mis_m = ((op_m == OP_LW) && (ALUout_M[1:0] != 2'b00)) ||
                (((op_m == OP_LH) || (op_m == OP_LHU)) && ALUout_M[0]);

        cap_d          = '0;
        cap_d.ir       = IR_M;
        cap_d.pc4      = PC4_M;
        cap_d.pc8      = PC8_M;
        cap_d.alu      = ALUout_M;
        cap_d.raw      = DMrd_M;
        cap_d.regwrite = regwrite_M & ~mis_m;
        cap_d.rdst     = (regwrite_M & ~mis_m) ? RDst_M : 5'd0;
        cap_d.valid    = 1'b1;
        cap_d.adel     = mis_m;

        // Bubble is a nop that still carries the PC trace forward
        bub_d     = '0;
        bub_d.pc4 = PC4_M;
        bub_d.pc8 = PC8_M;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      st_q <= RST_STATE;
        else if (flush)  st_q <= bub_d;
        else if (!stall) st_q <= cap_d;
    end

    assign IR_W       = st_q.ir;
    assign PC4_W      = st_q.pc4;
    assign PC8_W      = st_q.pc8;
    assign ALUout_W   = st_q.alu;
    assign RDst_W     = st_q.rdst;
    assign regwrite_W = st_q.regwrite;
    assign valid_W    = st_q.valid;
    assign adel_W     = st_q.adel;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (st_q.alu[1:0])
            2'd0:    byte_sel = st_q.raw[7:0];
            2'd1:    byte_sel = st_q.raw[15:8];
            2'd2:    byte_sel = st_q.raw[23:16];
            default: byte_sel = st_q.raw[31:24];
        endcase
        half_sel = st_q.alu[1] ? st_q.raw[31:16] : st_q.raw[15:0];

        case (st_q.ir[31:26])
            OP_LB:   DMout_W = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  DMout_W = {24'd0, byte_sel};
            OP_LH:   DMout_W = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  DMout_W = {16'd0, half_sel};
            default: DMout_W = st_q.raw;
        endcase
    end

`ifdef MW_RETIRE_CNT_EN
    // Counts the instruction leaving W: real, not held, not a faulting load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retire_cnt <= '0;
        else if (st_q.valid && !stall && !st_q.adel)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mw_pipe_reg.sv
// Bench for mw_pipe_reg: vector table, hand sequences for stall/flush/async reset,
// and randomized traffic against a behavioural model.
module tb_mw_pipe_reg;
    logic        clk = 1'b0, reset = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] IR_M = '0, PC4_M = '0, PC8_M = '0, ALUout_M = '0, DMrd_M = '0;
    logic [4:0]  RDst_M = '0;
    logic        regwrite_M = 1'b0;
    logic [31:0] IR_W, PC4_W, PC8_W, ALUout_W, DMout_W;
    logic [4:0]  RDst_W;
    logic        regwrite_W, valid_W, adel_W;
`ifdef MW_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int checks = 0, errors = 0;

    mw_pipe_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .IR_M(IR_M), .PC4_M(PC4_M), .PC8_M(PC8_M), .ALUout_M(ALUout_M),
        .DMrd_M(DMrd_M), .RDst_M(RDst_M), .regwrite_M(regwrite_M),
        .IR_W(IR_W), .PC4_W(PC4_W), .PC8_W(PC8_W), .ALUout_W(ALUout_W),
        .DMout_W(DMout_W), .RDst_W(RDst_W), .regwrite_W(regwrite_W),
        .valid_W(valid_W), .adel_W(adel_W)
`ifdef MW_RETIRE_CNT_EN
       ,.retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ir, m_pc4, m_pc8, m_alu, m_raw, m_cnt;
    logic [4:0]  m_rd;
    logic        m_rw, m_valid, m_adel;

    function automatic logic [31:0] load_val(input logic [31:0] ir, input logic [31:0] alu,
                                             input logic [31:0] raw);
        logic [31:0] b, h;
        b = (raw >> (8 * (alu % 4))) & 32'hFF;
        h = (raw >> (16 * ((alu / 2) % 2))) & 32'hFFFF;
        case (ir >> 26)
            32'h20:  return (b >= 128) ? b - 32'd256 : b;
            32'h24:  return b;
            32'h21:  return (h >= 32768) ? h - 32'd65536 : h;
            32'h25:  return h;
            default: return raw;
        endcase
    endfunction

    task automatic model_reset();
        m_ir = 0; m_alu = 0; m_raw = 0; m_rd = 0; m_rw = 0; m_valid = 0; m_adel = 0;
        m_pc4 = 32'h3004; m_pc8 = 32'h3008; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [31:0] op;
        logic        bad;
        if (m_valid && !stall && !m_adel) m_cnt = m_cnt + 1;
        op  = IR_M >> 26;
        bad = (op == 32'h23 && ALUout_M % 4 != 0) ||
              ((op == 32'h21 || op == 32'h25) && ALUout_M % 2 != 0);
        if (flush) begin
            m_ir = 0; m_rw = 0; m_rd = 0; m_valid = 0; m_adel = 0;
            m_pc4 = PC4_M; m_pc8 = PC8_M;
        end else if (!stall) begin
            m_ir = IR_M; m_pc4 = PC4_M; m_pc8 = PC8_M; m_alu = ALUout_M; m_raw = DMrd_M;
            m_rw = regwrite_M && !bad; m_rd = m_rw ? RDst_M : 5'd0;
            m_valid = 1; m_adel = bad;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".IR_W"}, IR_W, m_ir);
        chk({tag, ".PC4_W"}, PC4_W, m_pc4);
        chk({tag, ".PC8_W"}, PC8_W, m_pc8);
        chk({tag, ".RDst_W"}, 32'(RDst_W), 32'(m_rd));
        chk({tag, ".regwrite_W"}, 32'(regwrite_W), 32'(m_rw));
        chk({tag, ".valid_W"}, 32'(valid_W), 32'(m_valid));
        chk({tag, ".adel_W"}, 32'(adel_W), 32'(m_adel));
        if (m_valid) begin
            chk({tag, ".ALUout_W"}, ALUout_W, m_alu);
            chk({tag, ".DMout_W"}, DMout_W, load_val(m_ir, m_alu, m_raw));
        end
`ifdef MW_RETIRE_CNT_EN
        chk({tag, ".retire_cnt"}, retire_cnt, m_cnt);
`endif
    endtask

    task automatic set_in(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] dm,
                          input logic [4:0] rd, input logic rw, input logic [31:0] pc4,
                          input logic st, input logic fl);
        IR_M = ir; ALUout_M = alu; DMrd_M = dm; RDst_M = rd; regwrite_M = rw;
        PC4_M = pc4; PC8_M = pc4 + 32'd4; stall = st; flush = fl;
    endtask

    // Inputs already applied at a falling edge; capture, then sample at the next falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [31:0] ir, alu, dm;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] e_dm;
        logic [4:0]  e_rd;
        logic        e_rw, e_adel;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] r0, r1, r2, r3, r4;
        tbl[0] = '{32'h8C08_0004, 32'd4, 32'h1234_5678, 5'd8,  1'b1, 32'h1234_5678, 5'd8,  1'b1, 1'b0};
        tbl[1] = '{32'h8109_0003, 32'd3, 32'h80FF_0011, 5'd9,  1'b1, 32'hFFFF_FF80, 5'd9,  1'b1, 1'b0};
        tbl[2] = '{32'h9109_0003, 32'd3, 32'h80FF_0011, 5'd9,  1'b1, 32'h0000_0080, 5'd9,  1'b1, 1'b0};
        tbl[3] = '{32'h850A_0002, 32'd2, 32'h9ABC_0000, 5'd10, 1'b1, 32'hFFFF_9ABC, 5'd10, 1'b1, 1'b0};
        tbl[4] = '{32'h950A_0001, 32'd1, 32'h9ABC_0000, 5'd10, 1'b1, 32'h0000_0000, 5'd0,  1'b0, 1'b1};
        tbl[5] = '{32'h8C0B_0006, 32'd6, 32'h1111_2222, 5'd11, 1'b1, 32'h1111_2222, 5'd0,  1'b0, 1'b1};
        tbl[6] = '{32'h0109_5021, 32'd7, 32'hAABB_CCDD, 5'd10, 1'b1, 32'hAABB_CCDD, 5'd10, 1'b1, 1'b0};
        tbl[7] = '{32'h9005_0001, 32'd1, 32'h0000_AB00, 5'd5,  1'b0, 32'h0000_00AB, 5'd0,  1'b0, 1'b0};
        tbl[8] = '{32'h9403_0000, 32'd0, 32'h1234_8001, 5'd3,  1'b1, 32'h0000_8001, 5'd3,  1'b1, 1'b0};

        // reset state
        model_reset();
        @(negedge clk);
        chk("rst.IR_W", IR_W, 32'h0);
        chk("rst.PC4_W", PC4_W, 32'h0000_3004);
        chk("rst.PC8_W", PC8_W, 32'h0000_3008);
        chk("rst.valid_W", 32'(valid_W), 32'h0);
        chk("rst.regwrite_W", 32'(regwrite_W), 32'h0);
        chk("rst.RDst_W", 32'(RDst_W), 32'h0);
        chk("rst.DMout_W", DMout_W, 32'h0);
`ifdef MW_RETIRE_CNT_EN
        chk("rst.retire_cnt", retire_cnt, 32'h0);
`endif
        reset = 1'b1;

        // vector table
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].ir, tbl[i].alu, tbl[i].dm, tbl[i].rd, tbl[i].rw, 32'h100 + 32'(i) * 4, 1'b0, 1'b0);
            step();
            chk($sformatf("vec%0d.DMout_W", i), DMout_W, tbl[i].e_dm);
            chk($sformatf("vec%0d.RDst_W", i), 32'(RDst_W), 32'(tbl[i].e_rd));
            chk($sformatf("vec%0d.regwrite_W", i), 32'(regwrite_W), 32'(tbl[i].e_rw));
            chk($sformatf("vec%0d.adel_W", i), 32'(adel_W), 32'(tbl[i].e_adel));
            chk($sformatf("vec%0d.valid_W", i), 32'(valid_W), 32'h1);
            chk($sformatf("vec%0d.PC4_W", i), PC4_W, 32'h100 + 32'(i) * 4);
        end

        // stall holds everything while M inputs change
        set_in(tbl[0].ir, tbl[0].alu, tbl[0].dm, tbl[0].rd, tbl[0].rw, 32'h200, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            set_in(r0, r1, r2, r3[4:0], 1'b1, r3, 1'b1, 1'b0);
            step();
            chk("stall.IR_W", IR_W, 32'h8C08_0004);
            chk("stall.DMout_W", DMout_W, 32'h1234_5678);
            chk("stall.RDst_W", 32'(RDst_W), 32'd8);
            chk("stall.PC4_W", PC4_W, 32'h200);
            chk("stall.valid_W", 32'(valid_W), 32'h1);
        end

        // flush beats stall
        set_in(tbl[0].ir, tbl[0].alu, tbl[0].dm, tbl[0].rd, 1'b1, 32'h500, 1'b1, 1'b1);
        step();
        chk("flush.IR_W", IR_W, 32'h0);
        chk("flush.valid_W", 32'(valid_W), 32'h0);
        chk("flush.regwrite_W", 32'(regwrite_W), 32'h0);
        chk("flush.RDst_W", 32'(RDst_W), 32'h0);
        chk("flush.PC4_W", PC4_W, 32'h500);
        chk("flush.PC8_W", PC8_W, 32'h504);

        // asynchronous reset between edges, with stall asserted
        set_in(tbl[3].ir, tbl[3].alu, tbl[3].dm, tbl[3].rd, 1'b1, 32'h600, 1'b0, 1'b0);
        step();
        stall = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("arst.IR_W", IR_W, 32'h0);
        chk("arst.PC4_W", PC4_W, 32'h0000_3004);
        chk("arst.PC8_W", PC8_W, 32'h0000_3008);
        chk("arst.valid_W", 32'(valid_W), 32'h0);
        chk("arst.RDst_W", 32'(RDst_W), 32'h0);
        chk("arst.regwrite_W", 32'(regwrite_W), 32'h0);
        model_reset();
        @(negedge clk);
        stall = 1'b0;
        reset = 1'b1;

`ifdef MW_RETIRE_CNT_EN
        // 5 valid, 1 misaligned load, then flushes
        for (int i = 0; i < 5; i++) begin
            set_in(tbl[0].ir, tbl[0].alu, tbl[0].dm, tbl[0].rd, 1'b1, 32'(i) * 4, 1'b0, 1'b0);
            step();
        end
        set_in(tbl[5].ir, tbl[5].alu, tbl[5].dm, tbl[5].rd, 1'b1, 32'h40, 1'b0, 1'b0);
        step();
        set_in(0, 0, 0, 0, 1'b0, 32'h44, 1'b0, 1'b1);
        step();
        step();
        chk("retire.count5", retire_cnt, 32'd5);
        do_reset();
`endif

        // randomized traffic vs model
        for (int n = 0; n < 400; n++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
            case (r4 % 7)
                0: r0 = {6'h23, r0[25:0]};
                1: r0 = {6'h20, r0[25:0]};
                2: r0 = {6'h24, r0[25:0]};
                3: r0 = {6'h21, r0[25:0]};
                4: r0 = {6'h25, r0[25:0]};
                default: ;
            endcase
            set_in(r0, r1, r2, r3[4:0], r3[5], r3 & 32'hFFFF_FFFC,
                   (r4[10:9] == 2'b00), (r4[15:12] == 4'd0));
            step();
            check_all($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mw_pipe_reg.md
Name: mw_pipe_reg

Overview:
- Memory-to-writeback pipeline register; sits between the M stage and the W stage and feeds W's IR, PC4, PC8, ALUout, DMout and RDst inputs.
- Captures M-stage results on each clock and supports stall (hold) and flush (bubble insert).
- Extracts and sign/zero-extends load data from the raw data-memory word, so W always receives a finished DMout.
- Detects misaligned loads and suppresses the register write for them.

Parameters:
- RESET_PC, 32'h0000_3000, PC value implied for the reset bubble; PC4_W resets to RESET_PC+4 and PC8_W to RESET_PC+8.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold all registers this cycle.
- flush  in  1  load a bubble this cycle.
- IR_M  in  32  M-stage instruction word.
- PC4_M  in  32  M-stage PC+4.
- PC8_M  in  32  M-stage PC+8.
- ALUout_M  in  32  M-stage ALU result, also the load address.
- DMrd_M  in  32  raw word read from data memory at {ALUout_M[31:2],2'b00}.
- RDst_M  in  5  destination register number.
- regwrite_M  in  1  M-stage register-write enable.
- IR_W  out  32  registered instruction.
- PC4_W  out  32  registered PC+4.
- PC8_W  out  32  registered PC+8.
- ALUout_W  out  32  registered ALU result.
- DMout_W  out  32  extended load data.
- RDst_W  out  5  registered destination; forced to 0 when the write is suppressed.
- regwrite_W  out  1  registered write enable, already qualified.
- valid_W  out  1  1 = real instruction, 0 = bubble.
- adel_W  out  1  misaligned-load flag for the instruction now in W.

Behaviour:
- Reset (reset=0, asynchronous):
  - IR_W=0, ALUout_W=0, raw data reg=0, RDst_W=0.
  - regwrite_W=0, valid_W=0, adel_W=0.
  - PC4_W=RESET_PC+4, PC8_W=RESET_PC+8.
  - Release is synchronous to the next clk edge.
- Priority each rising edge: flush > stall > normal capture.
- Normal capture:
  - All *_M values move to *_W with one-cycle latency; valid_W<=1.
- Stall:
  - Every register, including valid_W and adel_W, holds its value.
- Flush:
  - IR_W<=0 (nop), regwrite_W<=0, RDst_W<=0, valid_W<=0, adel_W<=0.
  - PC4_W and PC8_W capture the M values, to keep the PC trace.
  - If flush and stall are both 1, flush wins.
- Load decode uses opcode IR_W[31:26] and byte offset ALUout_W[1:0]; DMout_W is combinational from registered state.
  - 0x23 lw: DMout_W = raw word.
  - 0x20 lb: byte at offset, sign-extended. Offset 0 selects bits [7:0] (little-endian).
  - 0x24 lbu: byte at offset, zero-extended.
  - 0x21 lh: half at ALUout_W[1] (0 selects [15:0], 1 selects [31:16]), sign-extended.
  - 0x25 lhu: half as for lh, zero-extended.
  - Any other opcode: DMout_W = raw word.
- Misalignment, evaluated at capture from IR_M/ALUout_M:
  - lw with ALUout_M[1:0]!=0, or lh/lhu with ALUout_M[0]=1 → adel_W<=1, regwrite_W<=0, RDst_W<=0.
  - DMout_W is still driven, but unused.
- regwrite_W = regwrite_M & ~misaligned at capture. RDst_W=0 whenever regwrite_W=0.
- Reset asserted mid-stall or mid-flush: reset dominates immediately.

Optional Feature:
- Macro: MW_RETIRE_CNT_EN.
- When defined, adds output retire_cnt (32 bits):
  - Reset value 0.
  - Increments by 1 on each edge where valid_W=1, stall=0 and adel_W=0; this counts the instruction leaving W.
  - Wraps from 32'hFFFF_FFFF to 0.
- When undefined: no port and no counter logic.

Test Plan:
- Reset then release; capture lw, IR_M=32'h8C08_0004, ALUout_M=4, DMrd_M=32'h1234_5678, regwrite_M=1, RDst_M=8 → next edge: DMout_W=32'h1234_5678, RDst_W=8, regwrite_W=1, valid_W=1.
- lb with opcode 0x20, ALUout_M=3, DMrd_M=32'h80FF_0011 → DMout_W=32'hFFFF_FF80. Same with lbu (0x24) → 32'h0000_0080.
- lh with ALUout_M=2, DMrd_M=32'h9ABC_0000 → DMout_W=32'hFFFF_9ABC. Then lhu with ALUout_M=1 → adel_W=1, regwrite_W=0, RDst_W=0.
- Stall=1 for 3 cycles while M inputs change → all W outputs unchanged. Stall=1 and flush=1 together → IR_W=0, valid_W=0, regwrite_W=0.
- Assert reset low mid-stream, asynchronously between edges → outputs go to reset values at once, with PC4_W=32'h0000_3004.
- With MW_RETIRE_CNT_EN: 5 valid instructions, 1 flush, 1 misaligned load → retire_cnt=5.
